// File: rtl/pipe_pkg.sv
// Shared EXE->MEM pipeline definitions: address width, control-bit positions
// and the occupancy/state encoding of the skid register.
package pipe_pkg;
  localparam int ADDRESS_LEN = 32;

  localparam int MEM_W_IDX = 2;
  localparam int MEM_R_IDX = 1;
  localparam int WB_IDX    = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/exe_mem_skid_reg_if.sv
// EXE->MEM handshake bundle: upstream valid/ready/payload plus downstream
// valid/ready/payload. The pipeline register uses the slave modport.
interface exe_mem_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_LEN,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3
) ();
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] alu_res_in;
  logic [ADDR_W-1:0] val_rm_in;
  logic [DEST_W-1:0] dest_in;
  logic [CTRL_W-1:0] ctrl_in;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] alu_res_out;
  logic [ADDR_W-1:0] val_rm_out;
  logic [DEST_W-1:0] dest_out;
  logic [CTRL_W-1:0] ctrl_out;

  modport master (
    output in_valid, pc_in, alu_res_in, val_rm_in, dest_in, ctrl_in, out_ready,
    input  in_ready, out_valid, pc, alu_res_out, val_rm_out, dest_out, ctrl_out
  );

  modport slave (
    input  in_valid, pc_in, alu_res_in, val_rm_in, dest_in, ctrl_in, out_ready,
    output in_ready, out_valid, pc, alu_res_out, val_rm_out, dest_out, ctrl_out
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry (payload + valid). Clear beats load; clear drops
// valid and the control bits so a killed entry cannot write anything.
module pipe_entry_reg #(
  parameter int ADDR_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] alu_res_i,
  input  logic [ADDR_W-1:0] val_rm_i,
  input  logic [DEST_W-1:0] dest_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] alu_res_o,
  output logic [ADDR_W-1:0] val_rm_o,
  output logic [DEST_W-1:0] dest_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d, alu_q, alu_d, rm_q, rm_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    rm_d    = rm_q;
    dest_d  = dest_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      alu_d   = alu_res_i;
      rm_d    = val_rm_i;
      dest_d  = dest_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      rm_q    <= '0;
      dest_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rm_q    <= rm_d;
      dest_q  <= dest_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = pc_q;
  assign alu_res_o = alu_q;
  assign val_rm_o  = rm_q;
  assign dest_o    = dest_q;
  assign ctrl_o    = ctrl_q;
endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a 2-entry skid buffer, flush and freeze.
// Define PERF_CNT_EN to add saturating stall_cnt/bubble_cnt outputs.
module exe_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W = ADDRESS_LEN,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  exe_mem_skid_reg_if.slave   bus,
  input  logic                flush,
  input  logic                freeze,
  output logic [2*DEST_W-1:0] fwd_dest,
  output logic [1:0]          fwd_wb,
  output logic [1:0]          occupancy
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0]  stall_cnt
  , output logic [CNT_W-1:0]  bubble_cnt
`endif
);
  occ_e state_q, state_d;
  logic push, pop;
  logic head_load, head_clear, head_from_skid, skid_load, skid_clear;

  logic              head_v, skid_v;
  logic [ADDR_W-1:0] head_pc, head_alu, head_rm, skid_pc, skid_alu, skid_rm;
  logic [DEST_W-1:0] head_dest, skid_dest;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;

  assign bus.in_ready = ~skid_v & ~freeze;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = head_v & bus.out_ready & ~freeze;

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: if (push) begin
          head_load = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            head_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: if (pop) begin
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  pipe_entry_reg #(.ADDR_W(ADDR_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_head (
    .clk       (clk),
    .rst       (rst),
    .load_i    (head_load),
    .clear_i   (head_clear),
    .pc_i      (head_from_skid ? skid_pc   : bus.pc_in),
    .alu_res_i (head_from_skid ? skid_alu  : bus.alu_res_in),
    .val_rm_i  (head_from_skid ? skid_rm   : bus.val_rm_in),
    .dest_i    (head_from_skid ? skid_dest : bus.dest_in),
    .ctrl_i    (head_from_skid ? skid_ctrl : bus.ctrl_in),
    .valid_o   (head_v),
    .pc_o      (head_pc),
    .alu_res_o (head_alu),
    .val_rm_o  (head_rm),
    .dest_o    (head_dest),
    .ctrl_o    (head_ctrl)
  );

  pipe_entry_reg #(.ADDR_W(ADDR_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (skid_load),
    .clear_i   (skid_clear),
    .pc_i      (bus.pc_in),
    .alu_res_i (bus.alu_res_in),
    .val_rm_i  (bus.val_rm_in),
    .dest_i    (bus.dest_in),
    .ctrl_i    (bus.ctrl_in),
    .valid_o   (skid_v),
    .pc_o      (skid_pc),
    .alu_res_o (skid_alu),
    .val_rm_o  (skid_rm),
    .dest_o    (skid_dest),
    .ctrl_o    (skid_ctrl)
  );

  assign bus.out_valid   = head_v;
  assign bus.pc          = head_pc;
  assign bus.alu_res_out = head_alu;
  assign bus.val_rm_out  = head_rm;
  assign bus.dest_out    = head_dest;
  // Control is masked so a stale entry can never look like a live write.
  assign bus.ctrl_out    = head_v ? head_ctrl : '0;

  assign fwd_dest  = {skid_dest, head_dest};
  assign fwd_wb    = {skid_v & skid_ctrl[WB_IDX], head_v & head_ctrl[WB_IDX]};
  assign occupancy = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (head_v && (!bus.out_ready || freeze) && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    if (!head_v && !flush && !(&bubble_q)) bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Self-checking bench for exe_mem_skid_reg: directed vector table, hand-written
// reset/flush/perf sequences and randomized traffic against a queue model.
module tb_exe_mem_skid_reg;
  import pipe_pkg::*;

  typedef struct {
    logic [31:0] pc, alu, rm;
    logic [3:0]  dest;
    logic [2:0]  ctrl;
  } pay_t;

  typedef struct {
    bit iv, ordy, frz, fl;
    logic [31:0] pc;
    bit          e_ov;
    logic [31:0] e_pc;
    logic [1:0]  e_occ;
    bit          e_rdy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, freeze;
  logic [7:0] fwd_dest;
  logic [1:0] fwd_wb, occupancy;

  exe_mem_skid_reg_if #(.ADDR_W(32), .DEST_W(4), .CTRL_W(3)) bus ();

`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic [3:0]  stall4, bubble4;
  logic [7:0]  fwd_dest4;
  logic [1:0]  fwd_wb4, occ4;
  exe_mem_skid_reg_if #(.ADDR_W(32), .DEST_W(4), .CTRL_W(3)) bus4 ();
  assign bus4.in_valid   = bus.in_valid;
  assign bus4.pc_in      = bus.pc_in;
  assign bus4.alu_res_in = bus.alu_res_in;
  assign bus4.val_rm_in  = bus.val_rm_in;
  assign bus4.dest_in    = bus.dest_in;
  assign bus4.ctrl_in    = bus.ctrl_in;
  assign bus4.out_ready  = bus.out_ready;
  exe_mem_skid_reg #(.ADDR_W(32), .DEST_W(4), .CTRL_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .flush(flush), .freeze(freeze),
    .fwd_dest(fwd_dest4), .fwd_wb(fwd_wb4), .occupancy(occ4),
    .stall_cnt(stall4), .bubble_cnt(bubble4)
  );
`endif

  exe_mem_skid_reg #(.ADDR_W(32), .DEST_W(4), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .freeze(freeze),
    .fwd_dest(fwd_dest), .fwd_wb(fwd_wb), .occupancy(occupancy)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  int   tests = 0;
  int   fails = 0;
  pay_t mq[$];
  bit   known = 0;
  int   stall_m = 0, bubble_m = 0;
  vec_t vt[$];

  function automatic pay_t mk(logic [31:0] p);
    pay_t r;
    r.pc   = p;
    r.alu  = p ^ 32'hA5A5_0000;
    r.rm   = ~p;
    r.dest = p[5:2];
    r.ctrl = {p[4], p[3], p[2]};
    return r;
  endfunction

  function automatic pay_t rnd_pay();
    pay_t r;
    r.pc   = $urandom;
    r.alu  = $urandom;
    r.rm   = $urandom;
    r.dest = 4'($urandom);
    r.ctrl = 3'($urandom);
    return r;
  endfunction

  function automatic vec_t V(bit iv, bit ordy, bit frz, bit fl, logic [31:0] pc,
                             bit ov, logic [31:0] epc, logic [1:0] occ, bit rdy);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.frz = frz; v.fl = fl; v.pc = pc;
    v.e_ov = ov; v.e_pc = epc; v.e_occ = occ; v.e_rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    if (mq.size() > 0) begin
      chk("pc", 64'(bus.pc), 64'(mq[0].pc));
      chk("alu_res", 64'(bus.alu_res_out), 64'(mq[0].alu));
      chk("val_rm", 64'(bus.val_rm_out), 64'(mq[0].rm));
      chk("dest", 64'(bus.dest_out), 64'(mq[0].dest));
      chk("ctrl", 64'(bus.ctrl_out), 64'(mq[0].ctrl));
      chk("fwd_dest_head", 64'(fwd_dest[3:0]), 64'(mq[0].dest));
      chk("fwd_wb_head", 64'(fwd_wb[0]), 64'(mq[0].ctrl[0]));
    end else begin
      chk("ctrl_idle", 64'(bus.ctrl_out), 64'd0);
      chk("fwd_wb_head_idle", 64'(fwd_wb[0]), 64'd0);
    end
    if (mq.size() > 1) begin
      chk("fwd_dest_skid", 64'(fwd_dest[7:4]), 64'(mq[1].dest));
      chk("fwd_wb_skid", 64'(fwd_wb[1]), 64'(mq[1].ctrl[0]));
    end else begin
      chk("fwd_wb_skid_idle", 64'(fwd_wb[1]), 64'd0);
    end
`ifdef PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`endif
  endtask

  // One clock: drive, check in_ready, advance the model, check outputs.
  task automatic step(input bit rn, input bit iv, input bit ordy, input bit frz,
                      input bit fl, input pay_t p);
    bit rdy_m, push, pop;
    rst = rn; flush = fl; freeze = frz;
    bus.in_valid = iv; bus.out_ready = ordy;
    bus.pc_in = p.pc; bus.alu_res_in = p.alu; bus.val_rm_in = p.rm;
    bus.dest_in = p.dest; bus.ctrl_in = p.ctrl;
    #1;
    rdy_m = (mq.size() < 2) && !frz;
    if (known) chk("in_ready", 64'(bus.in_ready), 64'(rdy_m));
    push = iv && rdy_m;
    pop  = (mq.size() > 0) && ordy && !frz;
    if (!rn) begin
      stall_m = 0; bubble_m = 0;
    end else begin
      if (mq.size() > 0 && (!ordy || frz) && stall_m < 65535) stall_m++;
      if (mq.size() == 0 && !fl && bubble_m < 65535) bubble_m++;
    end
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      known = 1;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(p);
    end
    #1;
    if (known) check_model();
  endtask

  initial begin
    pay_t z;
    z = mk(32'h0);

    // Reset held 3 cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(32'h200));
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ctrl", 64'(bus.ctrl_out), 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_pc", 64'(bus.pc), 64'd0);
      chk("rst_fwd", 64'({fwd_dest, fwd_wb}), 64'd0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, z);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Streaming, backpressure, freeze, flush, flush+freeze, frozen push.
    for (int k = 0; k < 8; k++)
      vt.push_back(V(1, 1, 0, 0, 32'h100 + 4 * k, 1, 32'h100 + 4 * k, 2'd1, 1));
    vt.push_back(V(0, 1, 0, 0, 32'h0,  0, 32'h0,  2'd0, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h10, 1, 32'h10, 2'd1, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h14, 1, 32'h10, 2'd2, 0));
    vt.push_back(V(1, 0, 0, 0, 32'h18, 1, 32'h10, 2'd2, 0));
    vt.push_back(V(0, 1, 0, 0, 32'h0,  1, 32'h14, 2'd1, 1));
    vt.push_back(V(0, 1, 0, 0, 32'h0,  0, 32'h0,  2'd0, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h20, 1, 32'h20, 2'd1, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h24, 1, 32'h20, 2'd2, 0));
    for (int k = 0; k < 4; k++)
      vt.push_back(V(0, 1, 1, 0, 32'h0, 1, 32'h20, 2'd2, 0));
    vt.push_back(V(0, 1, 0, 0, 32'h0,  1, 32'h24, 2'd1, 1));
    vt.push_back(V(0, 1, 0, 0, 32'h0,  0, 32'h0,  2'd0, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h30, 1, 32'h30, 2'd1, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h34, 1, 32'h30, 2'd2, 0));
    vt.push_back(V(1, 0, 0, 1, 32'h38, 0, 32'h0,  2'd0, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h40, 1, 32'h40, 2'd1, 1));
    vt.push_back(V(1, 0, 0, 0, 32'h44, 1, 32'h40, 2'd2, 0));
    vt.push_back(V(0, 1, 1, 1, 32'h0,  0, 32'h0,  2'd0, 0));
    vt.push_back(V(0, 1, 0, 0, 32'h0,  0, 32'h0,  2'd0, 1));
    vt.push_back(V(1, 0, 1, 0, 32'h50, 0, 32'h0,  2'd0, 0));
    vt.push_back(V(0, 0, 0, 0, 32'h0,  0, 32'h0,  2'd0, 1));

    foreach (vt[i]) begin
      step(1'b1, vt[i].iv, vt[i].ordy, vt[i].frz, vt[i].fl, mk(vt[i].pc));
      chk("tbl_out_valid", 64'(bus.out_valid), 64'(vt[i].e_ov));
      if (vt[i].e_ov) chk("tbl_pc", 64'(bus.pc), 64'(vt[i].e_pc));
      chk("tbl_occ", 64'(occupancy), 64'(vt[i].e_occ));
      chk("tbl_in_ready", 64'(bus.in_ready), 64'(vt[i].e_rdy));
    end

    // Reset while FULL drops both entries.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h60));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h64));
    chk("full_before_rst", 64'(occupancy), 64'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, z);
    chk("rst_mid_occ", 64'(occupancy), 64'd0);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);

`ifdef PERF_CNT_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h70));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, z);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, z);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, z);
    chk("perf_stall5", 64'(stall_cnt), 64'd5);
    chk("perf_bubble3", 64'(bubble_cnt), 64'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h74));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, z);
    chk("perf_sat4", 64'(stall4), 64'd15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z);
`endif

    // Randomized traffic, with occasional flush, freeze and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 8) == 0, ($urandom % 40) == 0, rnd_pay());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
